// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int STAT_W = 16;

  // Index width with a floor of one bit so single-entry ranges still get a signal.
  function automatic int ID_W(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority picker: first set bit of req at or above ptr, wrapping.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]          req,
  input  logic [ID_W(NUM_REQ)-1:0]    ptr,
  output logic                        found,
  output logic [ID_W(NUM_REQ)-1:0]    idx
);

  localparam int IW = ID_W(NUM_REQ);

  always_comb begin
    int j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter in front of a FIFO write port.
// Optional per-requester beat counters: define FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            fifo_full,
  output logic                            fifo_wr_en,
  output logic [DATA_WIDTH-1:0]           fifo_data,
  output logic [ID_W(NUM_REQ)-1:0]        grant_id,
  output logic                            busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]       stat_beats
`endif
);

  localparam int IW = ID_W(NUM_REQ);
  localparam int CW = ID_W(MAX_BURST);

  arb_state_e       state;
  logic [IW-1:0]    rr_ptr;
  logic [CW-1:0]    beat_cnt;
  logic             pick_found;
  logic [IW-1:0]    pick_idx;
  logic             sel_valid;
  logic             sel_last;
  logic             rel;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign busy       = (state == BURST);
  assign sel_valid  = req_valid[grant_id];
  assign sel_last   = req_last[grant_id];
  assign fifo_wr_en = busy & sel_valid & ~fifo_full;
  assign fifo_data  = busy ? req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH] : '0;

  // A stall (full) blocks every release path, including an abandoned request.
  assign rel = busy & ((fifo_wr_en & (sel_last | (beat_cnt == CW'(MAX_BURST-1))))
                     | (~sel_valid & ~fifo_full));

  always_comb begin
    req_ready = '0;
    if (fifo_wr_en) req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (pick_found) begin
          grant_id <= pick_idx;
          beat_cnt <= '0;
          state    <= BURST;
        end
        BURST: begin
          if (fifo_wr_en) beat_cnt <= beat_cnt + 1'b1;
          if (rel) begin
            state  <= IDLE;
            rr_ptr <= (grant_id == IW'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    logic [STAT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                   cnt <= '0;
      else if (req_ready[g] && cnt != {STAT_W{1'b1}}) cnt <= cnt + 1'b1;
    end
    assign stat_beats[g*STAT_W +: STAT_W] = cnt;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter; stats checks run when FIFO_ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_data;
  logic [1:0]        grant_id;
  logic              busy;
`ifdef FIFO_ARB_STATS_EN
  logic [NR*16-1:0]  stat_beats;
`endif

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_data  (fifo_data),
    .grant_id   (grant_id),
    .busy       (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_beats (stat_beats)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] d);
    req_data[i*DW +: DW] = d;
  endtask

  // One cycle: check outputs mid-cycle, then advance just past the next posedge.
  task automatic cyc(input string tag, input bit eb, input int eg, input bit ew,
                     input logic [DW-1:0] ed);
    logic [NR-1:0] er;
    er = '0;
    if (ew) er[eg] = 1'b1;
    @(negedge clk);
    chk({tag, ".busy"},  32'(busy),       32'(eb));
    chk({tag, ".wr_en"}, 32'(fifo_wr_en), 32'(ew));
    chk({tag, ".data"},  32'(fifo_data),  32'(ed));
    chk({tag, ".ready"}, 32'(req_ready),  32'(er));
    if (eb) chk({tag, ".gid"}, 32'(grant_id), 32'(eg));
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".busy"},  32'(busy),       32'd0);
    chk({tag, ".wr_en"}, 32'(fifo_wr_en), 32'd0);
    chk({tag, ".data"},  32'(fifo_data),  32'd0);
    chk({tag, ".ready"}, 32'(req_ready),  32'd0);
    chk({tag, ".gid"},   32'(grant_id),   32'd0);
  endtask

  initial begin
    int ord [5];
    ord = '{3, 0, 1, 2, 3};
    rst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Start a burst on req 0, then reset in the middle of it.
    req_valid = 4'b0001; set_data(0, 8'h55);
    cyc("pre_arb",  0, 0, 0, 8'h00);
    cyc("pre_beat", 1, 0, 1, 8'h55);
    rst_n = 1'b0; req_valid = '0;
    @(negedge clk); chk_reset_outputs("rst_a");
    @(negedge clk); chk_reset_outputs("rst_b");
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: single requester, three beats.
    req_valid = 4'b0100; set_data(2, 8'hA1);
    cyc("t1_arb", 0, 0, 0, 8'h00);
    cyc("t1_b1",  1, 2, 1, 8'hA1); set_data(2, 8'hA2);
    cyc("t1_b2",  1, 2, 1, 8'hA2); set_data(2, 8'hA3); req_last = 4'b0100;
    cyc("t1_b3",  1, 2, 1, 8'hA3); req_valid = '0; req_last = '0;
    cyc("t1_idle", 0, 0, 0, 8'h00);

    // 2: all valid, one-beat bursts; rr_ptr=3 so the order starts at 3.
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int i = 0; i < NR; i++) set_data(i, 8'(8'h10 + i));
    for (int k = 0; k < 5; k++) begin
      cyc("t2_bub", 0, 0, 0, 8'h00);
      cyc("t2_gnt", 1, ord[k], 1, 8'(8'h10 + ord[k]));
    end
    req_valid = '0; req_last = '0;
    cyc("t2_idle", 0, 0, 0, 8'h00);

    // 3: forced release after MAX_BURST, req 2 slips in, req 1 finishes.
    req_valid = 4'b0110; req_last = 4'b0100;
    set_data(1, 8'h31); set_data(2, 8'h2F);
    cyc("t3_arb", 0, 0, 0, 8'h00);
    for (int b = 0; b < MB; b++) begin
      cyc("t3_r1a", 1, 1, 1, 8'(8'h31 + b));
      set_data(1, 8'(8'h32 + b));
    end
    cyc("t3_rel", 0, 0, 0, 8'h00);
    cyc("t3_r2",  1, 2, 1, 8'h2F); req_valid = 4'b0010;
    cyc("t3_bub", 0, 0, 0, 8'h00);
    cyc("t3_r1b", 1, 1, 1, 8'h35); set_data(1, 8'h36); req_last = 4'b0010;
    cyc("t3_r1c", 1, 1, 1, 8'h36); req_valid = '0; req_last = '0;
    cyc("t3_idle", 0, 0, 0, 8'h00);

    // 4: full for 5 cycles after beat 2; valid dips during the stall.
    req_valid = 4'b0001; set_data(0, 8'h41);
    cyc("t4_arb", 0, 0, 0, 8'h00);
    cyc("t4_b1",  1, 0, 1, 8'h41); set_data(0, 8'h42);
    cyc("t4_b2",  1, 0, 1, 8'h42); set_data(0, 8'h43); fifo_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      req_valid = (s == 2) ? 4'b0000 : 4'b0001;
      cyc("t4_stall", 1, 0, 0, 8'h43);
    end
    req_valid = 4'b0001; fifo_full = 1'b0;
    cyc("t4_b3",  1, 0, 1, 8'h43); set_data(0, 8'h44); req_last = 4'b0001;
    cyc("t4_b4",  1, 0, 1, 8'h44); req_valid = '0; req_last = '0;
    cyc("t4_idle", 0, 0, 0, 8'h00);

    // 5: req 3 abandons after one beat; rr_ptr must wrap to 0.
    req_valid = 4'b1000; set_data(3, 8'h51);
    cyc("t5_arb",   0, 0, 0, 8'h00);
    cyc("t5_b1",    1, 3, 1, 8'h51); req_valid = '0;
    cyc("t5_aband", 1, 3, 0, 8'h51);
    req_valid = 4'b0011; req_last = 4'b0011; set_data(0, 8'h60); set_data(1, 8'h61);
    cyc("t5_idle",  0, 0, 0, 8'h00);
    cyc("t5_wrap",  1, 0, 1, 8'h60); req_valid = '0; req_last = '0;
    cyc("t5_end",   0, 0, 0, 8'h00);

`ifdef FIFO_ARB_STATS_EN
    // 6: eight one-beat grants from reset, then saturation of counter 0.
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      cyc("t6_bub", 0, 0, 0, 8'h00);
      cyc("t6_gnt", 1, k % NR, 1, 8'(8'h10 + (k % NR)));
    end
    req_valid = '0; req_last = '0;
    cyc("t6_idle", 0, 0, 0, 8'h00);
    for (int i = 0; i < NR; i++) chk("t6_stat", 32'(stat_beats[i*16 +: 16]), 32'd2);
    force dut.g_stat[0].cnt = 16'hFFFE;
    #1 release dut.g_stat[0].cnt;
    req_valid = 4'b0001; req_last = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      cyc("t6_sbub", 0, 0, 0, 8'h00);
      cyc("t6_sgnt", 1, 0, 1, 8'h10);
    end
    req_valid = '0; req_last = '0;
    cyc("t6_send", 0, 0, 0, 8'h00);
    chk("t6_sat",  32'(stat_beats[15:0]),  32'h0000FFFF);
    chk("t6_oth",  32'(stat_beats[31:16]), 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
